vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, the successor to the fixed-mode timing block at the head of the video pipeline. It produces horizontal/vertical counters, blanking, sync with configurable polarity, a data-enable flag and single-cycle line/frame start strobes. All geometry comes from parameters, and a pixel clock-enable lets it run from a faster system clock. Downstream draw stages consume its outputs exactly as they consume the current timing bus, plus the new flags.

---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces h/v counters, blanking, sync, data enable and line/frame start
// strobes. Every output is registered and decoded from the same next-count
// value, so all outputs describe the same pixel in the same cycle.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 800,
   parameter int H_FP      = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BP      = 88,
   parameter int V_ACTIVE  = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter int HSYNC_POL = 1,
   parameter int VSYNC_POL = 1,
   parameter int CNT_W     = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             de,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   // Active levels of the sync outputs; the inactive level is the inverse.
   localparam logic HS_ON = (HSYNC_POL != 0);
   localparam logic VS_ON = (VSYNC_POL != 0);

   // Reject geometries that cannot be represented or have empty regions.
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_width
      $error("vga_timing_gen: every porch and sync width must be at least 1");
   end
   if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_chk_cnt
      $error("vga_timing_gen: H_TOTAL-1 / V_TOTAL-1 do not fit in CNT_W bits");
   end

   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;
   logic             hblnk_next;
   logic             vblnk_next;
   logic             hsync_next;
   logic             vsync_next;

   // Next raster position and the flags decoded from it.
   always_comb begin
      h_next = hcount + CNT_W'(1);
      v_next = vcount;
      if (hcount == H_LAST) begin
         h_next = '0;
         v_next = (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
      end
      hblnk_next = (h_next >= H_ACT);
      vblnk_next = (v_next >= V_ACT);
      hsync_next = ((h_next >= H_SS) && (h_next < H_SE)) ? HS_ON : ~HS_ON;
      vsync_next = ((v_next >= V_SS) && (v_next < V_SE)) ? VS_ON : ~VS_ON;
   end

   // Register counts and flags together; reset parks on the last pixel so the
   // first enabled cycle lands on (0,0) with frame_start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount      <= H_LAST;
         vcount      <= V_LAST;
         hblnk       <= 1'b1;
         vblnk       <= 1'b1;
         de          <= 1'b0;
         hsync       <= ~HS_ON;
         vsync       <= ~VS_ON;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (ce) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= hblnk_next;
            vblnk       <= vblnk_next;
            de          <= ~hblnk_next & ~vblnk_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a small geometry
// (H 8/2/3/2 -> 15 pixels, V 4/1/2/1 -> 8 lines). Two instances share the
// stimulus: one with active-high sync, one with active-low sync.
module tb_vga_timing_gen;

   typedef struct {
      int h;
      int v;
      bit hs;
      bit vs;
      bit hb;
      bit vb;
      bit de;
      bit ls;
      bit fs;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       ce;
   logic [3:0] a_h, a_v, b_h, b_v;
   logic       a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs;
   logic       b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   exp_t q[$];

   // model state
   int mh = 14;
   int mv = 7;
   bit mls = 0;
   bit mfs = 0;

   // period checking controls, written only by the stimulus process
   int phase  = 0;
   int exp_lp = 0;
   int exp_fp = 0;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(4)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .hcount(a_h), .vcount(a_v), .hsync(a_hs), .vsync(a_vs),
      .hblnk(a_hb), .vblnk(a_vb), .de(a_de),
      .line_start(a_ls), .frame_start(a_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(0), .VSYNC_POL(0), .CNT_W(4)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs),
      .hblnk(b_hb), .vblnk(b_vb), .de(b_de),
      .line_start(b_ls), .frame_start(b_fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t reset_exp();
      exp_t e;
      e.h = 14; e.v = 7; e.hs = 0; e.vs = 0; e.hb = 1; e.vb = 1;
      e.de = 0; e.ls = 0; e.fs = 0;
      return e;
   endfunction

   function automatic exp_t model_exp();
      exp_t e;
      e.h  = mh;
      e.v  = mv;
      e.hb = (mh >= 8);
      e.vb = (mv >= 4);
      e.hs = (mh >= 10 && mh <= 12);
      e.vs = (mv >= 5 && mv <= 6);
      e.de = !e.hb && !e.vb;
      e.ls = mls;
      e.fs = mfs;
      return e;
   endfunction

   task automatic compare_all(input string tag, input exp_t e);
      chk({tag, ".hcount"},      int'(a_h),  e.h);
      chk({tag, ".vcount"},      int'(a_v),  e.v);
      chk({tag, ".hsync"},       int'(a_hs), int'(e.hs));
      chk({tag, ".vsync"},       int'(a_vs), int'(e.vs));
      chk({tag, ".hblnk"},       int'(a_hb), int'(e.hb));
      chk({tag, ".vblnk"},       int'(a_vb), int'(e.vb));
      chk({tag, ".de"},          int'(a_de), int'(e.de));
      chk({tag, ".line_start"},  int'(a_ls), int'(e.ls));
      chk({tag, ".frame_start"}, int'(a_fs), int'(e.fs));
      chk({tag, ".neg.hcount"},  int'(b_h),  e.h);
      chk({tag, ".neg.vcount"},  int'(b_v),  e.v);
      chk({tag, ".neg.hsync"},   int'(b_hs), int'(!e.hs));
      chk({tag, ".neg.vsync"},   int'(b_vs), int'(!e.vs));
      chk({tag, ".neg.de"},      int'(b_de), int'(e.de));
      chk({tag, ".neg.fs"},      int'(b_fs), int'(e.fs));
   endtask

   // One clock of normal operation: drive ce, advance the model, post expectation.
   task automatic cycle(input bit c);
      ce = c;
      @(posedge clk);
      #1;
      if (c) begin
         if (mh == 14) begin
            mh = 0;
            mv = (mv == 7) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
         mls = (mh == 0);
         mfs = mls && (mv == 0);
      end else begin
         mls = 0;
         mfs = 0;
      end
      q.push_back(model_exp());
   endtask

   // One clock with reset held and ce high: ce must be ignored.
   task automatic cycle_rst();
      ce = 1'b1;
      @(posedge clk);
      #1;
      q.push_back(reset_exp());
   endtask

   task automatic model_reset();
      mh = 14; mv = 7; mls = 0; mfs = 0;
   endtask

   // Monitor: pops one expectation per clock and checks strobe periods.
   initial begin : monitor
      exp_t e;
      int last_ls = -1;
      int last_fs = -1;
      int seen_phase = 0;
      forever begin
         @(negedge clk);
         if (phase != seen_phase || !rst_n) begin
            last_ls = -1;
            last_fs = -1;
            seen_phase = phase;
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            $display("[TB] cyc=%0d ce=%0b h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b exp h=%0d v=%0d",
                     cyc, ce, a_h, a_v, a_hs, a_vs, a_de, a_ls, a_fs, e.h, e.v);
            compare_all("scb", e);
         end
         if (a_ls) begin
            if (last_ls >= 0 && exp_lp > 0) chk("line_period", cyc - last_ls, exp_lp);
            last_ls = cyc;
         end
         if (a_fs) begin
            if (last_fs >= 0 && exp_fp > 0) chk("frame_period", cyc - last_fs, exp_fp);
            last_fs = cyc;
         end
      end
   end

   initial begin : stimulus
      int guard;
      rst_n = 1'b1;
      ce    = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      compare_all("reset_async", reset_exp());
      cycle_rst();
      cycle_rst();
      rst_n = 1'b1;

      // first enabled pixel is (0,0) with both strobes, then strobes drop
      cycle(1'b1);
      cycle(1'b1);
      cycle(1'b0);
      cycle(1'b1);

      // ce tied high: line every 15, frame every 120 cycles
      phase  = 1;
      exp_lp = 15;
      exp_fp = 120;
      for (int i = 0; i < 250; i++) cycle(1'b1);

      // ce every third cycle: line every 45, frame every 360 cycles
      phase  = 2;
      exp_lp = 45;
      exp_fp = 360;
      for (int i = 0; i < 250; i++) begin
         cycle(1'b1);
         cycle(1'b0);
         cycle(1'b0);
      end

      // run to (5,3) and assert reset between clock edges
      phase  = 3;
      exp_lp = 0;
      exp_fp = 0;
      guard  = 0;
      while (!(mh == 5 && mv == 3) && guard < 200) begin
         cycle(1'b1);
         guard++;
      end
      chk("reach_5_3", guard < 200 ? 1 : 0, 1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      compare_all("reset_mid", reset_exp());
      model_reset();
      cycle_rst();
      cycle_rst();
      rst_n = 1'b1;
      cycle(1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b1);

      ce = 1'b0;
      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      #1;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
